// File: rtl/multi_pulse_counter_pkg.sv
// Shared types, edge-mode constants and counter step helper for the pulse counter.
package pulse_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } snap_state_t;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Next count after an edge: wraps to zero or sticks at max_val.
    function automatic logic [31:0] sat_or_wrap_inc(input logic [31:0] cnt,
                                                   input logic [31:0] max_val,
                                                   input logic        sat_en);
        logic [31:0] nxt;
        if (cnt == max_val) begin
            nxt = sat_en ? max_val : 32'd0;
        end else begin
            nxt = cnt + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/multi_pulse_counter_if.sv
// Pulse inputs, clear and snapshot handshake of the multi-channel pulse counter.
interface multi_pulse_counter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 5
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] PULSE_IN;
    logic              CLR;
    logic [SEL_W-1:0]  CH_SEL;
    logic              SNAP_REQ;
    logic              SNAP_ACK;
    logic [CNT_W-1:0]  OUT_REG;
    logic [NUM_CH-1:0] OVF;
    logic              BUSY;

    modport master (
        output PULSE_IN, CLR, CH_SEL, SNAP_REQ,
        input  SNAP_ACK, OUT_REG, OVF, BUSY
    );

    modport slave (
        input  PULSE_IN, CLR, CH_SEL, SNAP_REQ,
        output SNAP_ACK, OUT_REG, OVF, BUSY
    );
endinterface

// File: rtl/multi_pulse_counter_sync.sv
// Per-channel synchroniser followed by a registered edge detector.
module pulse_sync_edge
    import pulse_cnt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pulse_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   edge_d;
    logic                   newer;
    logic                   older;

    // Edge qualification on the two most recent synchronised samples.
    always_comb begin
        newer = sync_q[SYNC_STAGES-2];
        older = sync_q[SYNC_STAGES-1];
        if (EDGE_MODE == EDGE_FALL) begin
            edge_d = ~newer & older;
        end else if (EDGE_MODE == EDGE_BOTH) begin
            edge_d = newer ^ older;
        end else begin
            edge_d = newer & ~older;
        end
    end

    // Shift the asynchronous input through the synchroniser and register the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/multi_pulse_counter.sv
// Multi-channel edge counter with sticky overflow and four-phase snapshot readout.
module multi_pulse_counter
    import pulse_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE,
    parameter int unsigned SAT_EN      = 0
) (
    input  logic                  SYS_CLK,
    input  logic                  A_RESET_N,
    multi_pulse_counter_if.slave  bus
);

    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [NUM_CH-1:0] pulse_edge;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    snap_state_t       state_q;
    snap_state_t       state_d;
    logic [CNT_W-1:0]  out_q;
    logic [CNT_W-1:0]  out_d;
    logic              ack_q;
    logic              ack_d;
    logic              busy_q;
    logic              busy_d;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        pulse_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync (
            .clk_i   (SYS_CLK),
            .rst_n_i (A_RESET_N),
            .pulse_i (bus.PULSE_IN[g]),
            .edge_o  (pulse_edge[g])
        );
    end

    // Counter and overflow update: clear wins over edge, edge over hold.
    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.CLR) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (pulse_edge[i]) begin
                cnt_d[i] = CNT_W'(sat_or_wrap_inc(32'(cnt_q[i]), CNT_MAX, SAT_EN != 0));
                if (32'(cnt_q[i]) == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Snapshot FSM next state; capture reads the registered (pre-update) count.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.SNAP_REQ) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                out_d = '0;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (bus.CH_SEL == SEL_W'(i)) begin
                        out_d = cnt_q[i];
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                if (!bus.SNAP_REQ) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    // Snapshot FSM state and registered handshake outputs.
    always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            state_q <= IDLE;
            out_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.SNAP_ACK = ack_q;
    assign bus.OUT_REG  = out_q;
    assign bus.OVF      = ovf_q;
    assign bus.BUSY     = busy_q;

endmodule
